wbm_spi_cmd: RTL
================

# wbm_spi_cmd

Command engine between the SPI byte stages and the Wishbone bus. It consumes bytes delivered by the SPI receive stage, already in the Wishbone clock domain, and parses them into single Wishbone B4 pipelined read or write transactions. It issues each transaction as bus master and hands status and read-data bytes to the SPI transmit stage. It is the only block that drives `wbm_*` signals.

## Interface
- `TIMEOUT`, default 255: cycles with `wbm_cyc_o` high and no ack before the transaction is aborted. Range 1..255.
- `wbm_clk_i`  in  1  system clock; the only clock.
- `wbm_rst_i`  in  1  synchronous, active-high reset.
- `rx_stb_i`  in  1  one-cycle strobe: `rx_data_i` holds a received byte. No backpressure.
- `rx_data_i`  in  8  received byte.
- `rx_start_i`  in  1  one-cycle pulse at each chip-select assertion (frame start).
- `tx_valid_o`  out  1  `tx_data_o` holds a byte to transmit.
- `tx_data_o`  out  8  byte to transmit.
- `tx_ready_i`  in  1  transmit stage accepts the byte when high together with `tx_valid_o`.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o`  out  1 each  Wishbone cycle, strobe, write enable.
- `wbm_sel_o`  out  4  byte selects.
- `wbm_adr_o`  out  8  word address.
- `wbm_dat_o`  out  32  write data.
- `wbm_dat_i`  in  32  read data.
- `wbm_stall_i`, `wbm_ack_i`  in  1 each  Wishbone stall and ack.

## Operation
- Frame format, MSB first:
  - byte 0 = command: bit7 = we, bits6:4 ignored, bits3:0 = sel.
  - byte 1 = address.
  - writes only: bytes 2..5 = data[31:24], [23:16], [15:8], [7:0].
- States: CMD, ADDR, WDATA, REQ, WAIT, RESP.
  - CMD: on `rx_stb_i`, latch we and sel, go to ADDR.
  - ADDR: on `rx_stb_i`, latch address. Go to WDATA if we=1, else REQ.
  - WDATA: shift in 4 bytes, counted by a 2-bit counter. After the 4th, go to REQ.
  - REQ: `cyc=stb=1`. Leave when `wbm_stall_i=0`: go to WAIT with `stb=0` and `cyc=1`. If ack arrives in that same cycle, go straight to RESP.
  - WAIT: hold `cyc=1` until `wbm_ack_i`. Latch `wbm_dat_i` on ack when we=0. Go to RESP.
  - RESP: emit the status byte. For reads, then emit 4 data bytes MSB first. Return to CMD after the last byte is accepted.
- Status byte:
  - bit0 = acked.
  - bit1 = timeout.
  - bit2 = overrun (sticky; cleared once reported).
  - bits7:3 = 0.
- Timeout:
  - An 8-bit counter is cleared on entry to REQ and increments every cycle in REQ and WAIT.
  - When the count reaches `TIMEOUT` without ack: drop `cyc` and `stb`, set timeout, go to RESP.
  - Read data bytes are still sent after a timeout, with value 0x00000000.
- Overrun: `rx_stb_i` in REQ, WAIT or RESP drops the byte and sets the overrun flag.
- `rx_start_i` in CMD, ADDR or WDATA returns the parser to CMD and discards the partial frame; no bus activity results.
- `rx_start_i` in REQ, WAIT or RESP is ignored. A bus transaction is never abandoned mid-cycle.
- `wbm_adr_o`, `wbm_sel_o`, `wbm_we_o` and `wbm_dat_o` are stable from entry to REQ until `cyc` falls.

## Timing
- Reset values, one cycle after `wbm_rst_i` high at a clock edge:
  - state = CMD; `wbm_cyc_o=0`, `wbm_stb_o=0`, `wbm_we_o=0`.
  - `wbm_sel_o=0`, `wbm_adr_o=0`, `wbm_dat_o=0`.
  - `tx_valid_o=0`, `tx_data_o=0`; all flags and counters cleared.
- Reset mid-transaction drops `cyc` and `stb` on the next edge.
- All outputs are registered.
- Bus request latency:
  - `rx_stb_i` of the last frame byte in cycle N gives `cyc=stb=1` in cycle N+1.
  - A single `stb` cycle is accepted per transaction when `stall=0`.
- Response latency:
  - Ack sampled in cycle M gives `tx_valid_o=1` with the status byte in cycle M+1.
  - Each accepted byte (`tx_valid_o & tx_ready_i`) presents the next byte in the following cycle, so one byte per cycle back-to-back.
- `tx_data_o` must not change while `tx_valid_o=1 & tx_ready_i=0`.
- An ack while `cyc=0` is ignored.

## Test plan
- Write: bytes 0x8F, 0x10, 0xDE, 0xAD, 0xBE, 0xEF, slave acks next cycle -> one stb with adr=0x10, sel=0xF, we=1, dat=0xDEADBEEF; tx emits 0x01.
- Read with stall: bytes 0x03, 0x22; slave stalls 3 cycles then acks with 0x12345678 -> stb held 4 cycles with stable adr=0x22, sel=0x3; tx emits 0x01, 0x12, 0x34, 0x56, 0x78.
- Timeout: `TIMEOUT`=8, read of 0x40, slave never acks -> `cyc` falls exactly 8 cycles after rising; tx emits 0x02 followed by four 0x00.
- Overrun: 2 extra rx bytes injected during WAIT -> status of this frame is 0x05; the next frame reports 0x01.
- Framing: 0x8F, 0x10, 0xAA, then `rx_start_i`, then a valid read frame -> no write on the bus; only the read executes.
- Backpressure and reset: `tx_ready_i` toggled randomly during RESP -> byte order and values preserved. Reset asserted during WAIT -> `cyc=0` next cycle; a following frame works normally.

Source files
------------

// File: rtl/wbm_spi_cmd.sv
// Parses SPI command frames (cmd, addr, optional 4 data bytes) into one Wishbone B4
// pipelined transaction, then streams a status byte and, for reads, 4 data bytes back.
module wbm_spi_cmd #(
  parameter int TIMEOUT = 255
) (
  input  logic        wbm_clk_i,
  input  logic        wbm_rst_i,
  input  logic        rx_stb_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_start_i,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_ready_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [7:0]  wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_stall_i,
  input  logic        wbm_ack_i
);

  typedef enum logic [2:0] {
    S_CMD   = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_REQ   = 3'd3,
    S_WAIT  = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  state_t      w_parse_state;

  logic        r_we;
  logic [3:0]  r_sel;
  logic [7:0]  r_adr;
  logic [31:0] r_wdat;
  logic [1:0]  r_wcnt;
  logic [7:0]  r_tmo_cnt;
  logic [31:0] r_rdata;
  logic [2:0]  r_bcnt;
  logic        r_ovr;
  logic        r_cyc;
  logic        r_stb;
  logic        r_tx_vld;
  logic [7:0]  r_tx_dat;

  logic        w_parse;
  logic        w_on_bus;
  logic        w_bus_ack;
  logic        w_tmo;
  logic        w_bus_end;
  logic        w_enter_req;
  logic        w_tx_acc;
  logic        w_last_byte;
  logic        w_ovr_set;
  logic        w_ovr_clr;
  logic        w_cyc_nxt;
  logic        w_stb_nxt;
  logic        w_tx_vld_nxt;

  assign w_parse   = (r_state == S_CMD) || (r_state == S_ADDR) || (r_state == S_WDATA);
  assign w_on_bus  = (r_state == S_REQ) || (r_state == S_WAIT);
  // A frame-start pulse restarts the parser; a byte arriving with it is the new command byte.
  assign w_parse_state = rx_start_i ? S_CMD : r_state;

  // Ack counts only once the strobe has been accepted; acks outside a cycle are ignored.
  assign w_bus_ack = ((r_state == S_REQ) && !wbm_stall_i && wbm_ack_i) ||
                     ((r_state == S_WAIT) && wbm_ack_i);
  assign w_tmo       = w_on_bus && (r_tmo_cnt == TMO_LAST);
  assign w_bus_end   = w_on_bus && (w_bus_ack || w_tmo);
  assign w_enter_req = w_parse && (w_state_nxt == S_REQ);
  assign w_tx_acc    = r_tx_vld && tx_ready_i;
  assign w_last_byte = r_we ? (r_bcnt == 3'd0) : (r_bcnt == 3'd4);
  assign w_ovr_set   = rx_stb_i && !w_parse;
  // Clear overrun only if the status byte being accepted actually carried it.
  assign w_ovr_clr   = w_tx_acc && (r_bcnt == 3'd0) && r_tx_dat[2];

  always_ff @(posedge wbm_clk_i) begin
    if (wbm_rst_i) begin
      r_state <= S_CMD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CMD, S_ADDR, S_WDATA: begin
        w_state_nxt = w_parse_state;
        if (rx_stb_i) begin
          case (w_parse_state)
            S_CMD:   w_state_nxt = S_ADDR;
            S_ADDR:  w_state_nxt = r_we ? S_WDATA : S_REQ;
            S_WDATA: w_state_nxt = (r_wcnt == 2'd3) ? S_REQ : S_WDATA;
            default: w_state_nxt = S_CMD;
          endcase
        end
      end
      S_REQ: begin
        if (w_bus_end) begin
          w_state_nxt = S_RESP;
        end else if (!wbm_stall_i) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_bus_end) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (w_tx_acc && w_last_byte) begin
          w_state_nxt = S_CMD;
        end
      end
      default: w_state_nxt = S_CMD;
    endcase
  end

  always_comb begin
    w_cyc_nxt    = (w_state_nxt == S_REQ) || (w_state_nxt == S_WAIT);
    w_stb_nxt    = (w_state_nxt == S_REQ);
    w_tx_vld_nxt = (w_state_nxt == S_RESP);
  end

  always_ff @(posedge wbm_clk_i) begin
    if (wbm_rst_i) begin
      r_cyc     <= 1'b0;
      r_stb     <= 1'b0;
      r_tx_vld  <= 1'b0;
      r_tx_dat  <= 8'h00;
      r_we      <= 1'b0;
      r_sel     <= 4'h0;
      r_adr     <= 8'h00;
      r_wdat    <= 32'h0;
      r_wcnt    <= 2'd0;
      r_tmo_cnt <= 8'h00;
      r_rdata   <= 32'h0;
      r_bcnt    <= 3'd0;
      r_ovr     <= 1'b0;
    end else begin
      r_cyc    <= w_cyc_nxt;
      r_stb    <= w_stb_nxt;
      r_tx_vld <= w_tx_vld_nxt;
      r_ovr    <= (r_ovr && !w_ovr_clr) || w_ovr_set;

      if (w_parse && rx_stb_i) begin
        case (w_parse_state)
          S_CMD: begin
            r_we  <= rx_data_i[7];
            r_sel <= rx_data_i[3:0];
          end
          S_ADDR: begin
            r_adr  <= rx_data_i;
            r_wcnt <= 2'd0;
          end
          S_WDATA: begin
            r_wdat <= {r_wdat[23:0], rx_data_i};
            r_wcnt <= r_wcnt + 2'd1;
          end
          default: ;
        endcase
      end

      if (w_enter_req) begin
        r_tmo_cnt <= 8'h00;
        r_rdata   <= 32'h0;
      end else if (w_on_bus) begin
        r_tmo_cnt <= r_tmo_cnt + 8'd1;
      end

      if (w_bus_end) begin
        r_tx_dat <= {5'b0, r_ovr || w_ovr_set, !w_bus_ack, w_bus_ack};
        r_bcnt   <= 3'd0;
        if (w_bus_ack && !r_we) begin
          r_rdata <= wbm_dat_i;
        end
      end else if ((r_state == S_RESP) && w_tx_acc) begin
        if (w_last_byte) begin
          r_tx_dat <= 8'h00;
          r_bcnt   <= 3'd0;
        end else begin
          r_tx_dat <= r_rdata[31:24];
          r_rdata  <= {r_rdata[23:0], 8'h00};
          r_bcnt   <= r_bcnt + 3'd1;
        end
      end
    end
  end

  assign wbm_cyc_o  = r_cyc;
  assign wbm_stb_o  = r_stb;
  assign wbm_we_o   = r_we;
  assign wbm_sel_o  = r_sel;
  assign wbm_adr_o  = r_adr;
  assign wbm_dat_o  = r_wdat;
  assign tx_valid_o = r_tx_vld;
  assign tx_data_o  = r_tx_dat;

endmodule
